// File: rtl/adder_tree_scheduler.sv
// adder_tree_scheduler: round-robin share of one adder_tree across NUM_REQ lanes.
// Ports: clk, rst_n; req_valid/req_ready/req_data (lanes in);
//   tree_operands/tree_result (shared tree); out_valid/out_ready/out_data/out_id (result out).
//   Optional ADDER_TREE_SCHED_STATS_EN adds accept_count, stall_count.
module adder_tree_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*10*DATA_WIDTH-1:0] req_data,
  output logic [10*DATA_WIDTH-1:0]         tree_operands,
  input  logic [DATA_WIDTH-1:0]            tree_result,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [ID_WIDTH-1:0]              out_id
`ifdef ADDER_TREE_SCHED_STATS_EN
  ,
  output logic [31:0]                      accept_count,
  output logic [31:0]                      stall_count
`endif
);

  localparam int OPW = 10 * DATA_WIDTH;

  logic                op_valid;
  logic [ID_WIDTH-1:0] op_id;
  logic [ID_WIDTH-1:0] rr;
  logic [ID_WIDTH-1:0] gnt;
  logic [ID_WIDTH-1:0] rr_nxt;
  logic                found;
  logic                accept;
  logic                s2_take;
  logic                s1_take;

  assign s2_take = !out_valid || out_ready;
  assign s1_take = !op_valid || s2_take;

  // Walk from the highest offset down so the lowest offset
  // from rr (the first valid lane in ring order) wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        gnt   = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
  end

  assign accept = found && s1_take && rst_n;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt] = 1'b1;
  end

  assign rr_nxt = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid      <= 1'b0;
      op_id         <= '0;
      tree_operands <= '0;
      rr            <= '0;
    end else if (s1_take) begin
      op_valid <= accept;
      // Operands only load on accept so the tree input stays quiet.
      if (accept) begin
        tree_operands <= req_data[int'(gnt)*OPW +: OPW];
        op_id         <= gnt;
        rr            <= rr_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (s2_take) begin
      out_valid <= op_valid;
      if (op_valid) begin
        out_data <= tree_result;
        out_id   <= op_id;
      end
    end
  end

`ifdef ADDER_TREE_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_count <= '0;
      stall_count  <= '0;
    end else begin
      if (accept) accept_count <= accept_count + 32'd1;
      if (out_valid && !out_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// tb_adder_tree_scheduler: directed bench for adder_tree_scheduler.
// Models the combinational adder_tree and checks outputs with assertions.
module tb_adder_tree_scheduler;

  localparam int DW  = 16;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int OPW = 10 * DW;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*OPW-1:0] req_data;
  logic [OPW-1:0]    tree_operands;
  logic [DW-1:0]     tree_result;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [IDW-1:0]    out_id;
`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [31:0]       accept_count;
  logic [31:0]       stall_count;
`endif

  int nvec;
  int nerr;

  adder_tree_scheduler #(
    .DATA_WIDTH(DW),
    .NUM_REQ(NR),
    .ID_WIDTH(IDW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .tree_operands(tree_operands),
    .tree_result(tree_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_id(out_id)
`ifdef ADDER_TREE_SCHED_STATS_EN
    ,
    .accept_count(accept_count),
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    tree_result = '0;
    for (int k = 0; k < 10; k++)
      tree_result = tree_result + tree_operands[k*DW +: DW];
  end

  function automatic logic [OPW-1:0] mk(input logic [DW-1:0] base,
                                        input logic [DW-1:0] step);
    logic [OPW-1:0] v;
    v = '0;
    for (int k = 0; k < 10; k++)
      v[k*DW +: DW] = base + DW'(k) * step;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [OPW-1:0] obs,
                     input logic [OPW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec      = 0;
    nerr      = 0;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < NR; i++)
      req_data[i*OPW +: OPW] = mk(DW'(i + 1), 16'd0);
    tick();
    tick();
    chk("rst_ready", OPW'(req_ready), OPW'(4'b0000));
    chk("rst_ovalid", OPW'(out_valid), OPW'(1'b0));
    chk("rst_odata", OPW'(out_data), '0);
    chk("rst_oid", OPW'(out_id), '0);
    chk("rst_ops", tree_operands, '0);

    rst_n = 1'b1;
    #1;
    chk("rel_grant0", OPW'(req_ready), OPW'(4'b0001));

    // Round robin with all lanes valid, out_ready high.
    for (int k = 0; k < 8; k++) begin
      chk("rr_ready", OPW'(req_ready), OPW'(4'b0001 << (k % 4)));
      tick();
      chk("rr_ovalid", OPW'(out_valid), OPW'(k >= 1));
      if (k >= 1) begin
        chk("rr_oid", OPW'(out_id), OPW'((k - 1) % 4));
        chk("rr_odata", OPW'(out_data), OPW'(10 * ((k - 1) % 4 + 1)));
      end
    end
    req_valid = 4'b0000;
    tick();
    chk("rr_last_v", OPW'(out_valid), OPW'(1'b1));
    chk("rr_last_id", OPW'(out_id), OPW'(3));
    chk("rr_last_d", OPW'(out_data), OPW'(40));
    tick();
    chk("rr_drain", OPW'(out_valid), OPW'(1'b0));

    // Single lane 2: products 1..9, bias 10 -> 55.
    req_data[2*OPW +: OPW] = mk(16'd1, 16'd1);
    req_valid = 4'b0100;
    #1;
    chk("sl_ready", OPW'(req_ready), OPW'(4'b0100));
    tick();
    req_valid = 4'b0000;
    chk("sl_n1", OPW'(out_valid), OPW'(1'b0));
    tick();
    chk("sl_n2_v", OPW'(out_valid), OPW'(1'b1));
    chk("sl_n2_d", OPW'(out_data), OPW'(16'd55));
    chk("sl_n2_id", OPW'(out_id), OPW'(2));
    tick();
    chk("sl_once", OPW'(out_valid), OPW'(1'b0));
    tick();
    chk("sl_once2", OPW'(out_valid), OPW'(1'b0));

    // Overflow on lane 1; pointer is at 3 so the search wraps to 1.
    req_data[1*OPW +: OPW] = mk(16'h7FFF, 16'd0);
    req_valid = 4'b0010;
    #1;
    chk("ov_ready", OPW'(req_ready), OPW'(4'b0010));
    tick();
    req_valid = 4'b0000;
    tick();
    chk("ov_v", OPW'(out_valid), OPW'(1'b1));
    chk("ov_d", OPW'(out_data), OPW'(16'hFFF6));
    chk("ov_id", OPW'(out_id), OPW'(1));
    tick();

    // Backpressure: lanes 3,0,1 (pointer at 2), out_ready low.
    req_data[1*OPW +: OPW] = mk(16'd2, 16'd0);
    out_ready = 1'b0;
    req_valid = 4'b1011;
    #1;
    chk("bp_g3", OPW'(req_ready), OPW'(4'b1000));
    tick();
    req_valid = 4'b0011;
    #1;
    chk("bp_g0", OPW'(req_ready), OPW'(4'b0001));
    tick();
    req_valid = 4'b0010;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready0", OPW'(req_ready), OPW'(4'b0000));
      chk("bp_ov", OPW'(out_valid), OPW'(1'b1));
      chk("bp_od", OPW'(out_data), OPW'(40));
      chk("bp_oid", OPW'(out_id), OPW'(3));
      chk("bp_ops", tree_operands, mk(16'd1, 16'd0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_g1", OPW'(req_ready), OPW'(4'b0010));
    tick();
    req_valid = 4'b0000;
    chk("bp_r2_id", OPW'(out_id), OPW'(0));
    chk("bp_r2_d", OPW'(out_data), OPW'(10));
    tick();
    chk("bp_r3_v", OPW'(out_valid), OPW'(1'b1));
    chk("bp_r3_id", OPW'(out_id), OPW'(1));
    chk("bp_r3_d", OPW'(out_data), OPW'(20));
    tick();
    chk("bp_end", OPW'(out_valid), OPW'(1'b0));

    // Async reset with two entries in flight (pointer at 2).
    out_ready = 1'b0;
    req_valid = 4'b0011;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    chk("ar_pre_v", OPW'(out_valid), OPW'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ov0", OPW'(out_valid), OPW'(1'b0));
    chk("ar_rdy0", OPW'(req_ready), OPW'(4'b0000));
    chk("ar_ops0", tree_operands, '0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("ar_nostale", OPW'(out_valid), OPW'(1'b0));
    end
    req_valid = 4'b1111;
    #1;
    chk("ar_ptr0", OPW'(req_ready), OPW'(4'b0001));
    tick();
    req_valid = 4'b0000;
    tick();
    chk("ar_post_v", OPW'(out_valid), OPW'(1'b1));
    chk("ar_post_id", OPW'(out_id), OPW'(0));
    chk("ar_post_d", OPW'(out_data), OPW'(10));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
